// File: rtl/hdc1080_axil_regs.sv
// HDC1080 AXI4-Lite register file: CTRL/STATUS/TEMP/HUM bridge to the I2C engine.
// Optional HDC_AXIL_IRQ_EN adds the CTRL[8] interrupt enable and the irq output.
module hdc1080_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            meas_start,
  output logic [2:0]                      meas_cfg,
  input  logic                            meas_busy,
  input  logic                            meas_done,
  input  logic [15:0]                     temp_in,
`ifdef HDC_AXIL_IRQ_EN
  output logic                            irq,
`endif
  input  logic [15:0]                     hum_in
);

  logic        aw_rdy;
  logic        b_vld;
  logic        ar_rdy;
  logic        r_vld;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;
  logic        start_q;
  logic [2:0]  cfg;
  logic        done;
  logic        ovr;
  logic        ier;
  logic [15:0] temp_q;
  logic [15:0] hum_q;
  logic        wr_fire;
  logic        rd_fire;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        clr_done;
  logic        clr_ovr;
  logic        unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR, S_AXI_ARADDR,
                    S_AXI_WDATA, S_AXI_WSTRB};

  assign wr_idx   = S_AXI_AWADDR[3:2];
  assign rd_idx   = S_AXI_ARADDR[3:2];
  assign wr_fire  = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire  = ar_rdy & S_AXI_ARVALID;
  assign wr_ctrl  = wr_fire & (wr_idx == 2'd0) & S_AXI_WSTRB[0];
  assign wr_stat  = wr_fire & (wr_idx == 2'd1) & S_AXI_WSTRB[0];
  assign clr_done = wr_stat & S_AXI_WDATA[1];
  assign clr_ovr  = wr_stat & S_AXI_WDATA[2];

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign meas_start    = start_q;
  assign meas_cfg      = cfg;

  always_comb begin
    rd_mux = 32'h0;
    unique case (rd_idx)
      2'd0: rd_mux = {23'h0, ier, 4'h0, cfg, 1'b0};
      2'd1: rd_mux = {29'h0, ovr, done, meas_busy};
      2'd2: rd_mux = {16'h0, temp_q};
      2'd3: rd_mux = {16'h0, hum_q};
    endcase
  end

  // AW and W are only accepted together, one beat per B response
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_rdy  <= 1'b0;
      b_vld   <= 1'b0;
      ar_rdy  <= 1'b0;
      r_vld   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      aw_rdy <= S_AXI_AWVALID & S_AXI_WVALID
              & ~b_vld & ~aw_rdy;
      if (wr_fire)
        b_vld <= 1'b1;
      else if (S_AXI_BREADY)
        b_vld <= 1'b0;
      ar_rdy <= S_AXI_ARVALID & ~r_vld & ~ar_rdy;
      if (rd_fire) begin
        r_vld   <= 1'b1;
        rdata_q <= rd_mux;
      end else if (S_AXI_RREADY) begin
        r_vld <= 1'b0;
      end
    end
  end

  // sticky flags: a same-cycle meas_done beats the W1C
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      start_q <= 1'b0;
      cfg     <= 3'h0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      temp_q  <= 16'h0;
      hum_q   <= 16'h0;
    end else begin
      start_q <= wr_ctrl & S_AXI_WDATA[0] & ~meas_busy;
      if (wr_ctrl)
        cfg <= S_AXI_WDATA[3:1];
      done <= meas_done | (done & ~clr_done);
      ovr  <= (meas_done & done) | (ovr & ~clr_ovr);
      if (meas_done) begin
        temp_q <= temp_in;
        hum_q  <= hum_in;
      end
    end
  end

`ifdef HDC_AXIL_IRQ_EN
  logic ier_q;
  logic irq_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ier_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_fire && wr_idx == 2'd0 && S_AXI_WSTRB[1])
        ier_q <= S_AXI_WDATA[8];
      irq_q <= ier_q & done;
    end
  end

  assign ier = ier_q;
  assign irq = irq_q;
`else
  assign ier = 1'b0;
`endif

endmodule

// File: tb/tb_hdc1080_axil_regs.sv
// Randomized self-checking bench for hdc1080_axil_regs.
// Reference model tracks register contents from the register-map rules.
module tb_hdc1080_axil_regs;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        meas_start;
  logic [2:0]  meas_cfg;
  logic        meas_busy = 1'b0;
  logic        meas_done = 1'b0;
  logic [15:0] temp_in = '0;
  logic [15:0] hum_in = '0;
`ifdef HDC_AXIL_IRQ_EN
  logic        irq;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;
  int start_cnt = 0;
  int acc_cnt   = 0;
  int start_exp = 0;

  logic [2:0]  m_cfg;
  logic        m_done;
  logic        m_ovr;
  logic        m_ier;
  logic [15:0] m_temp;
  logic [15:0] m_hum;

  hdc1080_axil_regs dut (
    .S_AXI_ACLK    (aclk),
    .S_AXI_ARESETN (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .meas_start    (meas_start),
    .meas_cfg      (meas_cfg),
    .meas_busy     (meas_busy),
    .meas_done     (meas_done),
    .temp_in       (temp_in),
`ifdef HDC_AXIL_IRQ_EN
    .irq           (irq),
`endif
    .hum_in        (hum_in)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (meas_start) start_cnt++;
    if (awready) acc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  task automatic model_reset();
    m_cfg = 0; m_done = 0; m_ovr = 0;
    m_ier = 0; m_temp = 0; m_hum = 0;
  endtask

  task automatic apply_write(input logic [3:0] a,
                             input logic [31:0] d,
                             input logic [3:0] s);
    case (a[3:2])
      2'd0: begin
        if (s[0]) begin
          m_cfg = d[3:1];
          if (d[0] && !meas_busy) start_exp++;
        end
`ifdef HDC_AXIL_IRQ_EN
        if (s[1]) m_ier = d[8];
`endif
      end
      2'd1: if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_ovr = 0;
      end
      default: ;
    endcase
  endtask

  task automatic apply_done(input logic [15:0] t,
                            input logic [15:0] h);
    if (m_done) m_ovr = 1;
    m_done = 1;
    m_temp = t;
    m_hum  = h;
  endtask

  function automatic logic [31:0] exp_reg(input logic [1:0] i);
    case (i)
      2'd0: return {23'd0, m_ier, 4'd0, m_cfg, 1'b0};
      2'd1: return {29'd0, m_ovr, m_done, meas_busy};
      2'd2: return {16'd0, m_temp};
      default: return {16'd0, m_hum};
    endcase
  endfunction

  task automatic do_write(input logic [3:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          input bit hold_b);
    int n;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge aclk); n++;
    end
    total_cnt++;
    if (awready !== 1'b1 || wready !== 1'b1)
      $display("FAIL wr_accept a=%h: aw=%b w=%b want 1 1",
               a, awready, wready);
    else pass_cnt++;
    if (awready === 1'b1) apply_write(a, d, s);
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    total_cnt++;
    if ({bvalid, bresp} !== 3'b100)
      $display("FAIL bresp: got v=%b r=%b want 1 00",
               bvalid, bresp);
    else pass_cnt++;
    if (!hold_b) begin
      bready = 1;
      @(negedge aclk);
      bready = 0;
    end
  endtask

  task automatic do_read(input logic [3:0] a,
                         output logic [31:0] d,
                         input bit hold_r);
    int n;
    @(negedge aclk);
    araddr = a; arvalid = 1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge aclk); n++;
    end
    total_cnt++;
    if (arready !== 1'b1)
      $display("FAIL rd_accept a=%h: got %b want 1", a, arready);
    else pass_cnt++;
    @(negedge aclk);
    arvalid = 0;
    total_cnt++;
    if ({rvalid, rresp} !== 3'b100)
      $display("FAIL rresp: got v=%b r=%b want 1 00",
               rvalid, rresp);
    else pass_cnt++;
    d = rdata;
    if (!hold_r) begin
      rready = 1;
      @(negedge aclk);
      rready = 0;
    end
  endtask

  task automatic pulse_done(input logic [15:0] t,
                            input logic [15:0] h);
    @(negedge aclk);
    meas_done = 1; temp_in = t; hum_in = h;
    @(negedge aclk);
    meas_done = 0;
    apply_done(t, h);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] got;
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), got, 0);
      total_cnt++;
      if (got !== exp_reg(2'(i)))
        $display("FAIL %s reg%0d: got %h want %h",
                 tag, i, got, exp_reg(2'(i)));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    #3 aresetn = 0;
    model_reset();
    repeat (3) @(negedge aclk);
    total_cnt++;
    if ({awready, wready, bvalid, arready, rvalid,
         meas_start, meas_cfg} !== 9'h0 || rdata !== 32'h0)
      $display("FAIL reset_outs: got %b rdata %h want 0",
               {awready, wready, bvalid, arready, rvalid,
                meas_start, meas_cfg}, rdata);
    else pass_cnt++;
    aresetn = 1;
    check_all("reset");
  endtask

  task automatic test_ctrl_start();
    int s0;
    logic [31:0] got;
    s0 = start_cnt;
    do_write(4'h0, 32'h0000000B, 4'hF, 0);
    repeat (2) @(negedge aclk);
    total_cnt++;
    if (start_cnt - s0 !== 1)
      $display("FAIL start_pulse: got %0d want 1", start_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (meas_cfg !== 3'b101)
      $display("FAIL meas_cfg: got %b want 101", meas_cfg);
    else pass_cnt++;
    do_read(4'h0, got, 0);
    total_cnt++;
    if (got !== 32'h0000000A)
      $display("FAIL ctrl_read: got %h want 0000000a", got);
    else pass_cnt++;
    meas_busy = 1;
    s0 = start_cnt;
    do_write(4'h0, 32'h00000003, 4'hF, 0);
    repeat (2) @(negedge aclk);
    meas_busy = 0;
    total_cnt++;
    if (start_cnt !== s0)
      $display("FAIL start_busy: got %0d want %0d", start_cnt, s0);
    else pass_cnt++;
  endtask

  task automatic test_measure();
    logic [31:0] got;
    pulse_done(16'h6A3C, 16'h8F10);
    do_read(4'h8, got, 0);
    total_cnt++;
    if (got !== 32'h00006A3C)
      $display("FAIL temp: got %h want 00006a3c", got);
    else pass_cnt++;
    do_read(4'hC, got, 0);
    total_cnt++;
    if (got !== 32'h00008F10)
      $display("FAIL hum: got %h want 00008f10", got);
    else pass_cnt++;
    do_read(4'h4, got, 0);
    total_cnt++;
    if (got !== 32'h00000002)
      $display("FAIL status_done: got %h want 00000002", got);
    else pass_cnt++;
  endtask

  task automatic write_with_done(input logic [31:0] d);
    int n;
    @(negedge aclk);
    awaddr = 4'h4; wdata = d; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge aclk); n++;
    end
    total_cnt++;
    if (awready !== 1'b1)
      $display("FAIL wd_accept: got %b want 1", awready);
    else pass_cnt++;
    meas_done = 1; temp_in = 16'h1234; hum_in = 16'h5678;
    @(negedge aclk);
    meas_done = 0; awvalid = 0; wvalid = 0;
    apply_write(4'h4, d, 4'hF);
    apply_done(16'h1234, 16'h5678);
    bready = 1;
    @(negedge aclk);
    bready = 0;
  endtask

  task automatic test_w1c();
    do_write(4'h4, 32'h2, 4'hF, 0);
    check_all("w1c_clear");
    pulse_done(16'h0101, 16'h0202);
    do_write(4'h4, 32'h0, 4'hF, 0);
    check_all("w1c_zero");
    pulse_done(16'h0303, 16'h0404);
    check_all("ovr_set");
    do_write(4'h4, 32'h6, 4'h0, 0);
    check_all("w1c_nostrb");
    do_write(4'h4, 32'h6, 4'hF, 0);
    check_all("w1c_both");
    write_with_done(32'h2);
    write_with_done(32'h4);
    check_all("set_wins");
  endtask

  task automatic test_backpressure();
    int n;
    bit bad;
    logic [31:0] got, hold, want;
    do_write(4'h0, 32'h00000004, 4'hF, 1);
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'h0000000C; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    bad = 0;
    repeat (10) begin
      @(negedge aclk);
      if (awready || wready || !bvalid) bad = 1;
    end
    total_cnt++;
    if (bad)
      $display("FAIL b_stall: got accept=1 want 0");
    else pass_cnt++;
    bready = 1;
    @(negedge aclk);
    bready = 0;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge aclk); n++;
    end
    total_cnt++;
    if (awready !== 1'b1)
      $display("FAIL b_release: got %b want 1", awready);
    else pass_cnt++;
    if (awready === 1'b1) apply_write(4'h0, 32'hC, 4'hF);
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    bready = 1;
    @(negedge aclk);
    bready = 0;
    want = exp_reg(2'd2);
    do_read(4'h8, got, 1);
    hold = rdata;
    pulse_done(16'hBEEF, 16'hCAFE);
    repeat (3) @(negedge aclk);
    total_cnt++;
    if (rdata !== hold || rvalid !== 1'b1 || got !== want)
      $display("FAIL r_stall: got %h v=%b want %h v=1",
               rdata, rvalid, want);
    else pass_cnt++;
    rready = 1;
    @(negedge aclk);
    rready = 0;
    check_all("bp_after");
  endtask

  task automatic test_aw_before_w();
    int a0, n;
    bit bad;
    a0 = acc_cnt;
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'h00000006; wstrb = 4'hF;
    awvalid = 1; wvalid = 0;
    bad = 0;
    repeat (3) begin
      @(negedge aclk);
      if (awready || wready) bad = 1;
    end
    total_cnt++;
    if (bad)
      $display("FAIL aw_only: got accept want none");
    else pass_cnt++;
    wvalid = 1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge aclk); n++;
    end
    if (awready === 1'b1) apply_write(4'h0, 32'h6, 4'hF);
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    bready = 1;
    repeat (3) @(negedge aclk);
    bready = 0;
    total_cnt++;
    if (acc_cnt - a0 !== 1)
      $display("FAIL aw_w_accepts: got %0d want 1", acc_cnt - a0);
    else pass_cnt++;
    check_all("aw_w");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_write(4'(i * 4), 32'(i + 1), 4'hF, 0);
    check_all("b2b");
  endtask

  task automatic test_random();
    logic [31:0] got, want;
    logic [3:0] a;
    for (int k = 0; k < 60; k++) begin
      meas_busy = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3:
          do_write(4'($urandom), $urandom,
                   4'($urandom), 0);
        4, 5:
          pulse_done(16'($urandom), 16'($urandom));
        default: begin
          a = 4'($urandom);
          do_read(a, got, 0);
          want = exp_reg(a[3:2]);
          total_cnt++;
          if (got !== want)
            $display("FAIL rand_rd a=%h: got %h want %h",
                     a, got, want);
          else pass_cnt++;
        end
      endcase
    end
    meas_busy = 0;
    repeat (2) @(negedge aclk);
    total_cnt++;
    if (start_cnt !== start_exp)
      $display("FAIL start_total: got %0d want %0d",
               start_cnt, start_exp);
    else pass_cnt++;
    check_all("rand_end");
  endtask

`ifdef HDC_AXIL_IRQ_EN
  task automatic test_irq();
    do_write(4'h4, 32'h6, 4'hF, 0);
    do_write(4'h0, 32'h100, 4'b0010, 0);
    repeat (2) @(negedge aclk);
    total_cnt++;
    if (irq !== 1'b0)
      $display("FAIL irq_idle: got %b want 0", irq);
    else pass_cnt++;
    pulse_done(16'h1111, 16'h2222);
    repeat (2) @(negedge aclk);
    total_cnt++;
    if (irq !== 1'b1)
      $display("FAIL irq_set: got %b want 1", irq);
    else pass_cnt++;
    do_write(4'h4, 32'h2, 4'hF, 0);
    total_cnt++;
    if (irq !== 1'b0)
      $display("FAIL irq_clr: got %b want 0", irq);
    else pass_cnt++;
    check_all("irq");
  endtask
`endif

  task automatic test_reset_mid();
    do_write(4'h4, 32'h0, 4'hF, 1);
    #2 aresetn = 0;
    #1;
    total_cnt++;
    if (bvalid !== 1'b0 || awready !== 1'b0 ||
        meas_cfg !== 3'h0)
      $display("FAIL reset_mid: got bv=%b cfg=%b want 0 000",
               bvalid, meas_cfg);
    else pass_cnt++;
    model_reset();
    @(negedge aclk);
    aresetn = 1;
    check_all("reset_mid");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ctrl_start();
    test_measure();
    test_w1c();
    test_backpressure();
    test_aw_before_w();
    test_back_to_back();
    test_random();
`ifdef HDC_AXIL_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
